// File: rtl/thread_fetch_scheduler.sv
// N-thread fetch front end: per-thread PCs, round-robin pick of one eligible thread per cycle.
// Latency 1: the selected thread's PC/tid appear on the registered outputs the cycle after issue.
// fetch_stall_i holds the presented fetch and blocks new issue; a redirect of the held thread kills it.
module thread_fetch_scheduler #(
  parameter int                    NUM_THREADS     = 4,
  parameter int                    TID_WIDTH       = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1,
  parameter int                    ADDR_WIDTH      = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC_BASE   = 'h0000_0000,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC_STRIDE = 'h0001_0000
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   fetch_stall_i,
  input  logic [NUM_THREADS-1:0] thread_enable_i,
  input  logic                   load_we_i,
  input  logic [TID_WIDTH-1:0]   load_tid_i,
  input  logic [ADDR_WIDTH-1:0]  load_pc_i,
  input  logic                   block_set_i,
  input  logic [TID_WIDTH-1:0]   block_set_tid_i,
  input  logic                   block_clr_i,
  input  logic [TID_WIDTH-1:0]   block_clr_tid_i,
  output logic                   valid_out_o,
  output logic [ADDR_WIDTH-1:0]  pc_out_o,
  output logic [TID_WIDTH-1:0]   tid_out_o
);

  logic [ADDR_WIDTH-1:0]  pc_q [NUM_THREADS];
  logic [ADDR_WIDTH-1:0]  pc_d [NUM_THREADS];
  logic [NUM_THREADS-1:0] blocked_q, blocked_d;
  logic [TID_WIDTH-1:0]   rr_ptr_q, rr_ptr_d;
  logic                   valid_q, valid_d;
  logic [ADDR_WIDTH-1:0]  pc_out_q, pc_out_d;
  logic [TID_WIDTH-1:0]   tid_out_q, tid_out_d;

  logic [NUM_THREADS-1:0] eligible;
  logic [TID_WIDTH-1:0]   scan_idx;
  logic [TID_WIDTH-1:0]   sel;
  logic                   any_elig;
  logic                   issue;
  logic [ADDR_WIDTH-1:0]  ipc;

  // Eligibility and round-robin selection; a block arriving this cycle already masks its thread.
  always_comb begin
    eligible = '0;
    scan_idx = '0;
    sel      = '0;
    any_elig = 1'b0;
    for (int t = 0; t < NUM_THREADS; t++) begin
      eligible[t] = thread_enable_i[t] & ~blocked_q[t] &
                    ~(block_set_i && (block_set_tid_i == TID_WIDTH'(t)));
    end
    for (int i = 0; i < NUM_THREADS; i++) begin
      scan_idx = TID_WIDTH'((int'(rr_ptr_q) + i) % NUM_THREADS);
      if (!any_elig && eligible[scan_idx]) begin
        any_elig = 1'b1;
        sel      = scan_idx;
      end
    end
    issue = ~fetch_stall_i & any_elig;
    // A redirect to the thread being issued this cycle is bypassed straight to the fetch.
    ipc   = (load_we_i && (load_tid_i == sel)) ? load_pc_i : pc_q[sel];
  end

  // Next-state: PC table, block flags, pointer and the presented fetch.
  always_comb begin
    blocked_d = blocked_q;
    rr_ptr_d  = rr_ptr_q;
    valid_d   = valid_q;
    pc_out_d  = pc_out_q;
    tid_out_d = tid_out_q;
    for (int t = 0; t < NUM_THREADS; t++) begin
      pc_d[t] = pc_q[t];
      if (issue && (sel == TID_WIDTH'(t))) begin
        pc_d[t] = ipc + ADDR_WIDTH'(4);
      end else if (load_we_i && (load_tid_i == TID_WIDTH'(t))) begin
        pc_d[t] = load_pc_i;
      end
      // Set wins over clear when both target the same thread.
      if (block_set_i && (block_set_tid_i == TID_WIDTH'(t))) begin
        blocked_d[t] = 1'b1;
      end else if (block_clr_i && (block_clr_tid_i == TID_WIDTH'(t))) begin
        blocked_d[t] = 1'b0;
      end
    end
    if (!fetch_stall_i) begin
      if (any_elig) begin
        valid_d   = 1'b1;
        tid_out_d = sel;
        pc_out_d  = ipc;
        rr_ptr_d  = (sel == TID_WIDTH'(NUM_THREADS - 1)) ? '0 : sel + TID_WIDTH'(1);
      end else begin
        valid_d   = 1'b0;
      end
    end else if (load_we_i && valid_q && (load_tid_i == tid_out_q)) begin
      // The held fetch belongs to a thread that was just redirected: it is stale.
      valid_d = 1'b0;
    end
  end

  // State registers with synchronous reset; reset PCs are spread by the stride.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int t = 0; t < NUM_THREADS; t++) begin
        pc_q[t] <= RESET_PC_BASE + ADDR_WIDTH'(t) * RESET_PC_STRIDE;
      end
      blocked_q <= '0;
      rr_ptr_q  <= '0;
      valid_q   <= 1'b0;
      pc_out_q  <= '0;
      tid_out_q <= '0;
    end else begin
      for (int t = 0; t < NUM_THREADS; t++) begin
        pc_q[t] <= pc_d[t];
      end
      blocked_q <= blocked_d;
      rr_ptr_q  <= rr_ptr_d;
      valid_q   <= valid_d;
      pc_out_q  <= pc_out_d;
      tid_out_q <= tid_out_d;
    end
  end

  assign valid_out_o = valid_q;
  assign pc_out_o    = pc_out_q;
  assign tid_out_o   = tid_out_q;

endmodule
